// File: rtl/hex_display_pkg.sv
// Shared definitions for the memory-mapped seven-segment controller:
// register map, CTRL bits, special glyphs, converter states, decoder.
package hex_display_pkg;

  localparam logic [1:0] REG_VALUE = 2'd0;
  localparam logic [1:0] REG_BLANK = 2'd1;
  localparam logic [1:0] REG_BLINK = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  localparam int CTRL_DEC  = 0;
  localparam int CTRL_LZS  = 1;
  localparam int CTRL_BUSY = 2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_LOAD
  } conv_state_t;

  // Active-low segments, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'ha: s = 7'b0001000;
      4'hb: s = 7'b0000011;
      4'hc: s = 7'b1000110;
      4'hd: s = 7'b0100001;
      4'he: s = 7'b0000110;
      4'hf: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_display_mm_bin2bcd.sv
// Sequential double-dabble converter: 32 shift cycles then one load.
// A full 10-digit BCD image is kept so overflow can be detected.
module bin2bcd_seq
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             bin,
  output logic                    busy,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf
);

  localparam int BW = 40;
  localparam int HI = 4 * NUM_DIGITS;

  conv_state_t      state;
  logic [4:0]       cnt;
  logic [BW+31:0]   sr;
  logic [BW+31:0]   adj;

  always_comb begin
    adj = sr;
    for (int k = 0; k < 10; k++) begin
      if (sr[32+4*k +: 4] >= 4'd5)
        adj[32+4*k +: 4] = sr[32+4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CONV_IDLE;
      cnt   <= '0;
      sr    <= '0;
      bcd   <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        CONV_IDLE: begin
          if (start) begin
            sr    <= {{BW{1'b0}}, bin};
            cnt   <= '0;
            state <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          sr  <= {adj[BW+30:0], 1'b0};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31)
            state <= CONV_LOAD;
        end
        CONV_LOAD: begin
          bcd   <= sr[32 +: HI];
          ovf   <= |sr[BW+31:32+HI];
          state <= CONV_IDLE;
        end
        default: state <= CONV_IDLE;
      endcase
    end
  end

  assign busy = (state != CONV_IDLE);

endmodule

// File: rtl/hex_display_mm.sv
// Avalon-MM seven-segment controller: register file, blink timer,
// per-digit glyph selection and registered segment outputs.
module hex_display_mm
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              address,
  input  logic                    read,
  input  logic                    write,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic                    waitrequest,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int ND = NUM_DIGITS;
  localparam int CW = $clog2(BLINK_DIV);

  logic [31:0]     value_q;
  logic [ND-1:0]   blank_q;
  logic [ND-1:0]   blink_q;
  logic            dec_q;
  logic            lzs_q;

  logic            busy;
  logic [4*ND-1:0] bcd;
  logic            ovf;

  logic            cv_reg;
  logic            accept;
  logic            next_dec;
  logic            start;
  logic [31:0]     conv_bin;

  logic [CW-1:0]   blink_cnt;
  logic            blink_off;

  logic [7*ND-1:0] seg_next;
  logic [3:0]      nib;
  logic            hi_zero;
  logic            dash;

  // Only VALUE/CTRL writes can retrigger the converter, so only they stall.
  assign cv_reg      = (address == REG_VALUE) || (address == REG_CTRL);
  assign waitrequest = write & cv_reg & busy;
  assign accept      = write & ~waitrequest;

  assign next_dec = (address == REG_CTRL) ? writedata[CTRL_DEC] : dec_q;
  assign start    = accept & cv_reg & next_dec;
  assign conv_bin = (address == REG_VALUE) ? writedata : value_q;

  bin2bcd_seq #(
    .NUM_DIGITS(ND)
  ) u_conv (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .bin  (conv_bin),
    .busy (busy),
    .bcd  (bcd),
    .ovf  (ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      blank_q <= '0;
      blink_q <= '0;
      dec_q   <= 1'b0;
      lzs_q   <= 1'b0;
    end else if (accept) begin
      unique case (address)
        REG_VALUE: value_q <= writedata;
        REG_BLANK: blank_q <= writedata[ND-1:0];
        REG_BLINK: blink_q <= writedata[ND-1:0];
        REG_CTRL: begin
          dec_q <= writedata[CTRL_DEC];
          lzs_q <= writedata[CTRL_LZS];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    if (read) begin
      unique case (address)
        REG_VALUE: readdata = value_q;
        REG_BLANK: readdata = 32'(blank_q);
        REG_BLINK: readdata = 32'(blink_q);
        REG_CTRL: begin
          readdata[CTRL_DEC]  = dec_q;
          readdata[CTRL_LZS]  = lzs_q;
          readdata[CTRL_BUSY] = busy;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Walk from the top digit down so hi_zero marks "nothing lit above".
  always_comb begin
    seg_next = '1;
    hi_zero  = 1'b1;
    nib      = '0;
    dash     = dec_q & ovf;
    for (int i = ND - 1; i >= 0; i--) begin
      nib     = dec_q ? bcd[4*i +: 4] : value_q[4*i +: 4];
      hi_zero = hi_zero & (nib == 4'd0);
      if (blank_q[i])
        seg_next[7*i +: 7] = SEG_BLANK;
      else if (blink_q[i] && blink_off)
        seg_next[7*i +: 7] = SEG_BLANK;
      else if (lzs_q && !dash && hi_zero && i > 0)
        seg_next[7*i +: 7] = SEG_BLANK;
      else if (dash)
        seg_next[7*i +: 7] = SEG_DASH;
      else
        seg_next[7*i +: 7] = seg7(nib);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hex_out <= '1;
    else     hex_out <= seg_next;
  end

endmodule

// File: tb/tb_hex_display_mm.sv
// Scoreboard bench for hex_display_mm: driver queues expected outputs
// from a behavioural model, a negedge monitor pops and compares them.
module tb_hex_display_mm;

  localparam int ND = 6;
  localparam int BD = 4;
  localparam logic [1:0] A_VALUE = 2'd0;
  localparam logic [1:0] A_BLANK = 2'd1;
  localparam logic [1:0] A_BLINK = 2'd2;
  localparam logic [1:0] A_CTRL  = 2'd3;
  localparam logic [41:0] ALL_ONES = {42{1'b1}};
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    address = '0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic          waitrequest;
  logic [7*ND-1:0] hex_out;

  hex_display_mm #(
    .NUM_DIGITS(ND),
    .BLINK_DIV (BD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .waitrequest(waitrequest),
    .hex_out    (hex_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          due;
    bit          is_read;
    logic [41:0] exp;
    string       name;
  } exp_t;
  exp_t sbq[$];

  logic [31:0]     m_value;
  logic [ND-1:0]   m_blank;
  logic [ND-1:0]   m_blink;
  bit              m_dec;
  bit              m_lzs;
  longint unsigned m_conv;
  int              rel_cyc;

  task automatic model_reset();
    m_value = '0; m_blank = '0; m_blink = '0;
    m_dec = 0; m_lzs = 0; m_conv = 0;
  endtask

  task automatic apply_write(input logic [1:0] a, input logic [31:0] d);
    case (a)
      A_VALUE: begin m_value = d; if (m_dec) m_conv = d; end
      A_BLANK: m_blank = d[ND-1:0];
      A_BLINK: m_blink = d[ND-1:0];
      default: begin
        m_dec = d[0]; m_lzs = d[1];
        if (m_dec) m_conv = m_value;
      end
    endcase
  endtask

  // Expected segments at cycle c (blink phase as of cycle c-1).
  function automatic logic [41:0] exp_hex(input int c);
    logic [41:0] r;
    logic [3:0]  dg [ND];
    longint unsigned p;
    bit off, dash;
    int msd;
    r = '1;
    off = (c - 1 >= rel_cyc) && ((((c - 1 - rel_cyc) / BD) % 2) == 1);
    dash = m_dec && (m_conv >= 64'd1000000);
    p = 1; msd = 0;
    for (int i = 0; i < ND; i++) begin
      if (m_dec) dg[i] = 4'((m_conv / p) % 10);
      else       dg[i] = 4'((m_value >> (4 * i)) & 32'hf);
      p = p * 10;
      if (dg[i] != 0) msd = i;
    end
    for (int i = 0; i < ND; i++) begin
      if (m_blank[i] || (m_blink[i] && off) || (m_lzs && !dash && i > msd))
        r[7*i +: 7] = 7'b1111111;
      else if (dash)
        r[7*i +: 7] = 7'b0111111;
      else
        r[7*i +: 7] = GLYPH[dg[i]];
    end
    return r;
  endfunction

  task automatic push(input int due, input bit rd,
                      input logic [41:0] e, input string n);
    exp_t it;
    it.due = due; it.is_read = rd; it.exp = e; it.name = n;
    sbq.push_back(it);
  endtask

  task automatic push_hex(input int due, input string n);
    push(due, 1'b0, exp_hex(due), n);
  endtask

  task automatic check(input string n, input longint act, input longint e);
    tests++;
    if (act != e) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, e, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due < cyc) begin
        check({sbq[i].name, "_missed"}, 1, 0);
        sbq.delete(i);
      end else if (sbq[i].due == cyc) begin
        if (sbq[i].is_read)
          check(sbq[i].name, longint'(readdata), longint'(sbq[i].exp));
        else
          check(sbq[i].name, longint'(hex_out), longint'(sbq[i].exp));
        sbq.delete(i);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d,
                          output int issued, output int acc);
    address = a; writedata = d; write = 1'b1;
    issued = cyc; acc = -1;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (!waitrequest) begin
        acc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (acc < 0) check("write_timeout", 1, 0);
    apply_write(a, d);
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d,
                    output int acc);
    int iss;
    do_write(a, d, iss, acc);
  endtask

  task automatic read_at(input int c, input logic [1:0] a,
                         input logic [31:0] e, input string n);
    wait_until(c);
    address = a; read = 1'b1;
    push(cyc, 1'b1, 42'(e), n);
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  function automatic logic [31:0] ctrl_exp(input bit busy);
    return {29'd0, busy, m_lzs, m_dec};
  endfunction

  int t, t2, iss;
  logic [31:0] v;
  logic [31:0] dec_vals [6] = '{32'd1234, 32'd999999, 32'd1000000,
                                32'd0, 32'd7, 32'hffffffff};

  initial begin
    model_reset();
    rel_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    address = A_VALUE; read = 1'b1;
    push(cyc, 1'b1, 42'd0, "rst_readdata");
    push(cyc, 1'b0, ALL_ONES, "rst_hex");
    @(posedge clk); #1;
    read = 1'b0; rst = 1'b0;
    rel_cyc = cyc;
    push(cyc, 1'b0, ALL_ONES, "rst_release_hold");
    push_hex(cyc + 1, "rst_release_zero");
    wait_until(rel_cyc + 3);

    // Hex mode, with and without leading-zero suppression.
    for (int lz = 0; lz < 2; lz++) begin
      wr(A_CTRL, 32'(lz << 1), t);
      for (int k = 0; k < 6; k++) begin
        v = $urandom >> $urandom_range(0, 28);
        wr(A_VALUE, v, t);
        push_hex(t + 2, "hex_value");
        wait_until(t + 3);
      end
    end

    // Register readback, unused bits and read-during-write.
    wr(A_BLANK, 32'hffffffff, t);
    push_hex(t + 2, "blank_all");
    read_at(t + 1, A_BLANK, 32'h3f, "blank_mask");
    wr(A_BLANK, 32'h0, t);
    wr(A_BLINK, 32'hffffffc5, t);
    read_at(t + 1, A_BLINK, 32'h05, "blink_mask");
    wr(A_BLINK, 32'h0, t);
    address = A_VALUE; writedata = 32'hcafe1234;
    write = 1'b1; read = 1'b1;
    push(cyc, 1'b1, 42'(m_value), "read_during_write");
    apply_write(A_VALUE, 32'hcafe1234);
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0;
    read_at(cyc, A_VALUE, 32'hcafe1234, "value_readback");

    // Decimal mode: conversion timing, BUSY window, overflow.
    wr(A_CTRL, 32'h3, t);
    wait_until(t + 36);
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin
        wr(A_CTRL, 32'h1, t);
        wait_until(t + 36);
      end
      v = (k < 6) ? dec_vals[k] : 32'($urandom_range(0, 2000000));
      wr(A_VALUE, v, t);
      push_hex(t + 35, "dec_digits");
      read_at(t + 1, A_CTRL, ctrl_exp(1), "busy_first");
      read_at(t + 33, A_CTRL, ctrl_exp(1), "busy_last");
      read_at(t + 34, A_CTRL, ctrl_exp(0), "busy_clear");
      wait_until(t + 36);
    end

    // Stalled VALUE write during a conversion.
    wr(A_VALUE, 32'd55555, t);
    wait_until(t + 5);
    do_write(A_VALUE, 32'd271828, iss, t2);
    check("stall_accept_cycle", t2, t + 34);
    push_hex(t2 + 35, "stall_final");
    wait_until(t2 + 36);

    // Blink and blank in hex mode.
    wr(A_CTRL, 32'h0, t);
    wr(A_VALUE, 32'h123456, t);
    wr(A_BLINK, 32'h1, t);
    wr(A_BLANK, 32'h2, t);
    for (int c = 0; c < 20; c++) push_hex(t + 2 + c, "blink_blank");
    wait_until(t + 23);
    wr(A_BLINK, 32'h0, t);
    wr(A_BLANK, 32'h0, t);

    // Reset in the middle of a conversion.
    wr(A_CTRL, 32'h1, t);
    wait_until(t + 36);
    wr(A_VALUE, 32'd4321, t);
    wait_until(t + 3);
    do_write(A_BLANK, 32'h3, iss, t2);
    check("blank_no_stall", t2, iss);
    wait_until(t + 10);
    rst = 1'b1;
    address = A_CTRL; read = 1'b1;
    push(cyc, 1'b0, ALL_ONES, "rst_mid_hex");
    push(cyc, 1'b1, 42'd0, "rst_mid_ctrl");
    @(posedge clk); #1;
    read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rel_cyc = cyc;
    model_reset();
    push(cyc, 1'b0, ALL_ONES, "rst2_hold");
    push_hex(cyc + 1, "rst2_zero");
    push_hex(cyc + 40, "rst2_no_late_load");
    read_at(cyc + 2, A_CTRL, 32'd0, "rst2_ctrl");
    wait_until(rel_cyc + 41);

    for (int n = 0; n < 100 && sbq.size() > 0; n++) @(posedge clk);
    if (sbq.size() > 0) check("scoreboard_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
